reg_bank_mp: RTL and testbench
==============================

Name: reg_bank_mp

Overview:
- Parametrised multi-port register bank for the datapath. It is the successor of the single-write, dual-read bank.
- It has N_RD registered read ports and one write port, with write-to-read bypass.
- Register 0 can optionally be hardwired to zero.
- After reset, a hardware clear sequencer zeroes every entry, so no memory-init file is needed.
- Sits between decode (addresses) and execute (operands); the writeback stage drives the write port.

Parameters:
- DATA_W, 32, bits per register.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- N_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  packed registered read data; port i uses slice [i*DATA_W +: DATA_W].
- busy  out  1  high while the clear sequence runs.
- wr_drop  out  1  one-cycle pulse when a write was ignored.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to S_CLEAR and clr_idx resets to 0.
  - rd_data is all 0, busy=1, wr_drop=0.
  - Entry contents are not touched by reset itself; they are zeroed by the clear sequence.
- S_CLEAR:
  - Each cycle writes 0 to entry clr_idx, then clr_idx increments.
  - When clr_idx=DEPTH-1 has been written, the next state is S_READY and busy falls.
  - Duration: exactly DEPTH cycles after rst_n is released (busy high for DEPTH cycles).
  - User writes are ignored; wr_drop pulses 1 in the cycle after each such wr_en=1.
  - rd_data is held at 0.
- S_READY, write:
  - If wr_en=1, mem[wr_addr] <= wr_data at the rising edge.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded silently (no wr_drop).
- S_READY, read:
  - Read latency is 1 cycle: rd_data[i] at edge k+1 reflects rd_addr[i] sampled at edge k.
- Bypass:
  - If wr_en=1 and wr_addr==rd_addr[i] in the same cycle, rd_data[i] returns wr_data (write-first).
  - This does not apply to address 0 when ZERO_REG=1; that case returns 0.
- Reads of address 0 with ZERO_REG=1 always return 0.
- Multiple read ports may address the same entry; each port returns the same value.
- Reset asserted mid-clear restarts the sequence at clr_idx=0.
- Reset asserted mid-operation aborts any write presented in that cycle.
- Width rule: rd_data/wr_data are DATA_W; no sign extension is performed; addresses are unsigned.
- No X on any output after the first reset edge.

Decomposition:
- Package reg_bank_pkg holds:
  - state enum {S_CLEAR, S_READY};
  - a function to index a packed port slice.
- One natural sub-module: reg_bank_clear_seq.
  - Contains the FSM and clr_idx counter.
  - Outputs busy, clr_we and clr_addr.
  - The top muxes clr_we/clr_addr/0 onto the write port when busy=1.
- Storage plus read/bypass logic stays in the top level, using a generate loop over N_RD.

Test Plan:
- Reset then release, DEPTH=32 → busy=1 for exactly 32 cycles; afterwards reading addr 0..31 on both ports returns 0 for all.
- Write 0xDEADBEEF to addr 5, then the next cycle read addr 5 on port 0 → rd_data[0]=0xDEADBEEF one cycle later; port 1 reading addr 6 → 0.
- Same cycle: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr[1]=7 → rd_data[1]=0x12345678 at the next edge (bypass).
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 while port 0 reads addr 0 → rd_data[0]=0; a later read also returns 0; wr_drop=0.
- wr_en=1 at the third cycle of S_CLEAR → wr_drop pulses 1 for one cycle; after busy falls, that address reads 0.
- Assert rst_n=0 at clear cycle 10 for 1 cycle → busy stays 1 for a further 32 cycles; rd_data=0 throughout.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the multi-port register bank
package reg_bank_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    // Lowest bit of port idx inside a packed bus of w-bit slices
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/reg_bank_clear_seq.sv
// reg_bank_clear_seq: post-reset sequencer that walks every entry once to zero it
module reg_bank_clear_seq
    import reg_bank_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    // Step through the entries and leave S_CLEAR after the last one is written
    always_comb begin
        state_d   = (state_q == S_CLEAR && clr_idx_q == ADDR_W'(DEPTH - 1)) ? S_READY : state_q;
        clr_idx_d = (state_q == S_CLEAR) ? clr_idx_q + ADDR_W'(1) : clr_idx_q;
    end

    // Reset restarts the sweep from entry 0, even mid-clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign busy     = (state_q == S_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = clr_idx_q;

endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: N_RD registered read ports, one write port, write-first bypass, optional zero register
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  DEPTH    = 32,
    parameter int  N_RD     = 2,
    parameter bit  ZERO_REG = 1'b1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic                   busy,
    output logic                   wr_drop
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_zero;
    logic              wr_drop_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    reg_bank_clear_seq #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign wr_zero = ZERO_REG && (wr_addr == '0);

    // The sequencer owns the write port while clearing; user writes to a hardwired zero entry vanish
    always_comb begin
        mem_we    = busy ? clr_we : (wr_en && !wr_zero);
        mem_waddr = busy ? clr_addr : wr_addr;
        mem_wdata = busy ? '0 : wr_data;
    end

    // Storage is never reset directly; a write presented in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    // Flag user writes swallowed by the clear sequence, one cycle later
    always_ff @(posedge clk) begin
        wr_drop_q <= rst_n && busy && wr_en;
    end

    assign wr_drop = wr_drop_q;

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_q, rd_d;

        assign ra = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        // Zero while clearing or for the zero register, else write-first bypass over the array
        always_comb begin
            rd_d = (busy || (ZERO_REG && ra == '0)) ? '0 :
                   (wr_en && wr_addr == ra) ? wr_data : mem_q[ra];
        end

        // Registered read with one cycle of latency
        always_ff @(posedge clk) begin
            rd_q <= !rst_n ? '0 : rd_d;
        end

        assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: directed stimulus with a due-cycle scoreboard checked by an independent monitor
module tb_reg_bank_mp;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] val;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra0, ra1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        busy;
    logic        wr_drop;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    item_t sb[$];

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bank_mp dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .busy   (busy),
        .wr_drop(wr_drop)
    );

    function automatic string nm(input int k);
        return k == 0 ? "rd_data0" : k == 1 ? "rd_data1" : k == 2 ? "busy" : "wr_drop";
    endfunction

    // Monitor: compare every expectation that has come due at this falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            item_t       it;
            logic [31:0] act;
            it  = sb.pop_front();
            act = it.kind == 0 ? rd_data[31:0] : it.kind == 1 ? rd_data[63:32] :
                  it.kind == 2 ? {31'b0, busy} : {31'b0, wr_drop};
            checks++;
            if (act !== it.val) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", nm(it.kind), cyc, act, it.val);
            end
        end
    end

    task automatic exp(input int k, input logic [31:0] v);
        sb.push_back('{due: cyc + 1, kind: k, val: v});
    endtask

    task automatic set(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        ra0     = a0;
        ra1     = a1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        exp(2, 32'd1); exp(0, 32'h0); exp(1, 32'h0); exp(3, 32'h0);
        tick();
        rst_n = 1'b1;
        // Clear sweep: busy falls at the 32nd edge; a write on the third edge is dropped
        for (int j = 1; j <= 32; j++) begin
            set(j == 3, 5'd1, 32'hCAFEF00D, 5'(j), 5'(j + 7));
            exp(2, 32'(j < 32)); exp(0, 32'h0); exp(1, 32'h0); exp(3, 32'(j == 3));
            tick();
        end
        // Every entry reads back zero on both ports
        for (int a = 0; a < 32; a++) begin
            set(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            exp(0, 32'h0); exp(1, 32'h0); exp(2, 32'h0);
            tick();
        end
        set(1'b1, 5'd5, 32'hDEADBEEF, 5'd6, 5'd6);
        exp(0, 32'h0); exp(1, 32'h0);
        tick();
        set(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        exp(0, 32'hDEADBEEF); exp(1, 32'h0);
        tick();
        // Same-cycle write and read of entry 7 returns the new data
        set(1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7);
        exp(0, 32'hDEADBEEF); exp(1, 32'h12345678); exp(3, 32'h0);
        tick();
        set(1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        exp(0, 32'h12345678); exp(1, 32'hDEADBEEF);
        tick();
        // Zero register ignores writes and its bypass
        set(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        exp(0, 32'h0); exp(1, 32'h0);
        tick();
        set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        exp(0, 32'h0); exp(1, 32'h0); exp(3, 32'h0);
        tick();
        // Both ports on one entry
        set(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        exp(0, 32'hDEADBEEF); exp(1, 32'hDEADBEEF);
        tick();
        // Reset again, then interrupt the clear at its tenth cycle
        rst_n = 1'b0;
        set(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        exp(2, 32'd1); exp(0, 32'h0); exp(1, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            exp(2, 32'd1); exp(0, 32'h0); exp(1, 32'h0);
            tick();
        end
        rst_n = 1'b0;
        exp(2, 32'd1); exp(0, 32'h0); exp(1, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            exp(2, 32'(j < 32)); exp(0, 32'h0); exp(1, 32'h0);
            tick();
        end
        set(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
        exp(0, 32'h0); exp(1, 32'h0); exp(2, 32'h0);
        tick();
        set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int t = 0; t < 10 && sb.size() > 0; t++) tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
